// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute/write-back stage: opcodes, FSM state
// encoding and register address width.
package alu_pkg;

    localparam int ADDR_W = 3;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_SLL  = 3'b101;
    localparam logic [OP_W-1:0] OP_SRL  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU. The shifter is only built when ALU_SHIFT_EN is defined;
// otherwise SLL/SRL fall through to PASS.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result_o = a_i;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: {carry_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB: begin
                result_o = a_i - b_i;
                carry_o  = (a_i < b_i);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
`ifdef ALU_SHIFT_EN
            OP_SLL: result_o = a_i << b_i[1:0];
            OP_SRL: result_o = a_i >> b_i[1:0];
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// Execute/write-back stage for the 8x4 mini register file: IDLE->READ->EXEC->WB.
// Optional shifter controlled by ALU_SHIFT_EN (see alu_core).
module alu_writeback
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   op_code,
    input  logic [ADDR_W-1:0] op_rs1,
    input  logic [ADDR_W-1:0] op_rs2,
    input  logic [ADDR_W-1:0] op_rd,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [WIDTH-1:0]  rd_data1,
    input  logic [WIDTH-1:0]  rd_data2,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_data,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              done
);

    logic [1:0]        state_q, state_d;
    logic [OP_W-1:0]   code_q;
    logic [ADDR_W-1:0] rd_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              op_ready_q;
    logic [ADDR_W-1:0] rd_addr1_q, rd_addr2_q;
    logic              wb_we_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [WIDTH-1:0]  wb_data_q;
    logic              flag_zero_q, flag_carry_q;
    logic              done_q;

    logic [WIDTH-1:0]  alu_result;
    logic              alu_carry;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (code_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (op_valid) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latches are reset along with everything else so a reset
    // mid-instruction leaves no stale operands behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            code_q       <= '0;
            rd_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_ready_q   <= 1'b1;
            rd_addr1_q   <= '0;
            rd_addr2_q   <= '0;
            wb_we_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            wb_we_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        code_q     <= op_code;
                        rd_q       <= op_rd;
                        rd_addr1_q <= op_rs1;
                        rd_addr2_q <= op_rs2;
                        op_ready_q <= 1'b0;
                    end
                end
                ST_READ: begin
                    a_q <= rd_data1;
                    b_q <= rd_data2;
                end
                ST_EXEC: begin
                    flag_zero_q  <= (alu_result == '0);
                    flag_carry_q <= alu_carry;
                    wb_data_q    <= alu_result;
                    wb_addr_q    <= rd_q;
                    // r0 is hardwired zero, so its write is dropped but the op still retires.
                    wb_we_q      <= (rd_q != '0);
                    done_q       <= 1'b1;
                end
                ST_WB: op_ready_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign op_ready   = op_ready_q;
    assign rd_addr1   = rd_addr1_q;
    assign rd_addr2   = rd_addr2_q;
    assign wb_we      = wb_we_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign flag_zero  = flag_zero_q;
    assign flag_carry = flag_carry_q;
    assign done       = done_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with a behavioural 8x4 register file model.
// Expected SLL/SRL results follow ALU_SHIFT_EN.
module tb_alu_writeback;
    import alu_pkg::*;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [2:0]       op_code = '0;
    logic [2:0]       op_rs1 = '0;
    logic [2:0]       op_rs2 = '0;
    logic [2:0]       op_rd = '0;
    logic [2:0]       rd_addr1, rd_addr2;
    logic [WIDTH-1:0] rd_data1, rd_data2;
    logic             wb_we;
    logic [2:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             flag_zero, flag_carry, done;

    int checks = 0;
    int errors = 0;

    // Register file model: async read, write on the rising edge; bench preload port.
    logic [WIDTH-1:0] rf [8];
    logic             load_en = 1'b0;
    logic [2:0]       load_addr = '0;
    logic [WIDTH-1:0] load_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) rf[load_addr] <= load_data;
        else if (wb_we && wb_addr != 3'd0) rf[wb_addr] <= wb_data;
    end

    assign rd_data1 = rf[rd_addr1];
    assign rd_data2 = rf[rd_addr2];

    alu_writeback #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_rs1     (op_rs1),
        .op_rs2     (op_rs2),
        .op_rd      (op_rd),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .done       (done)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [2:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Issues one instruction and checks every cycle up to the return to IDLE.
    task automatic run_op(input string tag, input logic [2:0] code, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic [2:0] rd,
                          input logic [3:0] exp_data, input logic exp_we,
                          input logic exp_carry, input logic exp_zero);
        @(negedge clk);
        check({tag, "_ready_idle"}, 8'(op_ready), 8'd1);
        op_valid = 1'b1;
        op_code  = code;
        op_rs1   = rs1;
        op_rs2   = rs2;
        op_rd    = rd;
        @(posedge clk);
        #1 op_valid = 1'b0;
        check({tag, "_ready_busy"}, 8'(op_ready), 8'd0);
        check({tag, "_raddr"}, {2'b0, rd_addr1, rd_addr2}, {2'b0, rs1, rs2});
        @(posedge clk);
        #1;
        check({tag, "_exec_we_done"}, {6'b0, wb_we, done}, 8'd0);
        @(posedge clk);
        #1;
        check({tag, "_wb_we"}, 8'(wb_we), 8'(exp_we));
        check({tag, "_wb_addr"}, 8'(wb_addr), 8'(rd));
        check({tag, "_wb_data"}, 8'(wb_data), 8'(exp_data));
        check({tag, "_done"}, 8'(done), 8'd1);
        check({tag, "_flags"}, {6'b0, flag_carry, flag_zero}, {6'b0, exp_carry, exp_zero});
        @(posedge clk);
        #1;
        check({tag, "_post_we_done"}, {6'b0, wb_we, done}, 8'd0);
        check({tag, "_post_ready"}, 8'(op_ready), 8'd1);
        check({tag, "_flags_hold"}, {6'b0, flag_carry, flag_zero}, {6'b0, exp_carry, exp_zero});
        if (exp_we) check({tag, "_rf"}, 8'(rf[rd]), 8'(exp_data));
    endtask

    logic [3:0] exp_sll, exp_srl;
    int         we_seen;

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = '0;
`ifdef ALU_SHIFT_EN
        exp_sll = 4'hC;
        exp_srl = 4'h3;
`else
        exp_sll = 4'h3;
        exp_srl = 4'hC;
`endif
        #12;
        check("reset_ready", 8'(op_ready), 8'd1);
        check("reset_outs", {rd_addr1, rd_addr2, wb_we, done},  8'd0);
        check("reset_wb", {wb_addr, wb_data, flag_zero}, 8'd0);
        check("reset_carry", 8'(flag_carry), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        load(3'd1, 4'd5);
        load(3'd2, 4'd3);
        run_op("add", OP_ADD, 3'd1, 3'd2, 3'd4, 4'd8, 1'b1, 1'b0, 1'b0);

        load(3'd1, 4'd9);
        load(3'd2, 4'd9);
        run_op("add_ovf", OP_ADD, 3'd1, 3'd2, 3'd5, 4'd2, 1'b1, 1'b1, 1'b0);

        load(3'd1, 4'd3);
        load(3'd2, 4'd5);
        run_op("sub_borrow", OP_SUB, 3'd1, 3'd2, 3'd6, 4'd14, 1'b1, 1'b1, 1'b0);
        run_op("sub_equal", OP_SUB, 3'd1, 3'd1, 3'd6, 4'd0, 1'b1, 1'b0, 1'b1);
        run_op("xor_zero", OP_XOR, 3'd1, 3'd1, 3'd7, 4'd0, 1'b1, 1'b0, 1'b1);

        load(3'd2, 4'hA);
        run_op("pass_r0", OP_PASS, 3'd2, 3'd0, 3'd0, 4'hA, 1'b0, 1'b0, 1'b0);
        check("r0_untouched", 8'(rf[0]), 8'd0);

        load(3'd1, 4'h3);
        load(3'd2, 4'h2);
        run_op("sll", OP_SLL, 3'd1, 3'd2, 3'd3, exp_sll, 1'b1, 1'b0, 1'b0);

        load(3'd1, 4'hC);
        load(3'd2, 4'h6);
        run_op("srl", OP_SRL, 3'd1, 3'd2, 3'd3, exp_srl, 1'b1, 1'b0, 1'b0);
        run_op("and", OP_AND, 3'd1, 3'd2, 3'd4, 4'h4, 1'b1, 1'b0, 1'b0);
        run_op("or", OP_OR, 3'd1, 3'd2, 3'd4, 4'hE, 1'b1, 1'b0, 1'b0);

        // Handshake: op_valid held high; accepts only every 4th cycle.
        load(3'd1, 4'h0);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = OP_PASS;
        op_rs1   = 3'd1;
        op_rs2   = 3'd1;
        op_rd    = 3'd1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("hs_ready_%0d", i), 8'(op_ready), 8'((i % 4) == 0));
            check($sformatf("hs_done_%0d", i), 8'(done), 8'((i % 4) == 3));
        end
        @(negedge clk);
        op_valid = 1'b0;
        check("hs_ready_end", 8'(op_ready), 8'd1);
        check("hs_flags", {6'b0, flag_carry, flag_zero}, 8'd1);

        // Reset during EXEC: abandon the ADD, no write ever issued.
        load(3'd4, 4'h0);
        load(3'd1, 4'd5);
        load(3'd2, 4'd3);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = OP_ADD;
        op_rs1   = 3'd1;
        op_rs2   = 3'd2;
        op_rd    = 3'd4;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_exec_ready", 8'(op_ready), 8'd1);
        check("rst_exec_outs", {rd_addr1, rd_addr2, wb_we, done}, 8'd0);
        check("rst_exec_wb", {wb_addr, wb_data, flag_zero}, 8'd0);
        check("rst_exec_carry", 8'(flag_carry), 8'd0);
        we_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_we) we_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_we) we_seen++;
        end
        check("rst_exec_no_we", 8'(we_seen), 8'd0);
        check("rst_exec_rf", 8'(rf[4]), 8'd0);
        check("rst_exec_ready_after", 8'(op_ready), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Execute-and-write-back stage that sits beside the 8-entry, 4-bit mini register file. It accepts one ALU instruction at a time through a valid/ready handshake and drives the register file's two read addresses. It captures the asynchronously read operands, computes a result, and drives the register file's write port (`we`, write address, write data) for exactly one cycle. Together with the register file it forms a minimal two-read/one-write datapath.

## Interface
- `WIDTH`, 4, data width; must match the register file width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `op_valid`  in  1  instruction present.
- `op_ready`  out  1  stage idle; can accept an instruction.
- `op_code`  in  3  operation select.
- `op_rs1`  in  3  source register 1 address.
- `op_rs2`  in  3  source register 2 address.
- `op_rd`  in  3  destination register address.
- `rd_addr1`  out  3  to register file read port 1.
- `rd_addr2`  out  3  to register file read port 2.
- `rd_data1`  in  WIDTH  from register file read port 1 (combinational read).
- `rd_data2`  in  WIDTH  from register file read port 2.
- `wb_we`  out  1  register file write enable.
- `wb_addr`  out  3  register file write address.
- `wb_data`  out  WIDTH  register file write data.
- `flag_zero`  out  1  last result == 0.
- `flag_carry`  out  1  carry (ADD) or borrow (SUB) of the last arithmetic op.
- `done`  out  1  one-cycle pulse when an instruction retires.

## Operation
- **FSM states:** IDLE → READ → EXEC → WB → IDLE. All outputs are registered.
- **IDLE**
  - `op_ready` = 1.
  - On `op_valid && op_ready`, latch `op_code`, `op_rs1`, `op_rs2` and `op_rd`, then go to READ.
  - `op_valid` is ignored while `op_ready` = 0.
- **READ**
  - `rd_addr1` and `rd_addr2` hold the latched `rs1` and `rs2`.
  - At the end of the cycle, latch `rd_data1` as A and `rd_data2` as B. Go to EXEC.
- **EXEC**
  - Compute the result and register it together with the flags. Go to WB.
  - Opcodes (results are truncated to WIDTH):
    - 000: ADD, A+B.
    - 001: SUB, A−B.
    - 010: AND.
    - 011: OR.
    - 100: XOR.
    - 101: SLL, A << B[1:0].
    - 110: SRL, A >> B[1:0] (logical).
    - 111: PASS, A.
  - `flag_carry`:
    - ADD: bit WIDTH of the (WIDTH+1)-bit sum.
    - SUB: 1 when A < B (unsigned).
    - All other ops: cleared to 0.
  - `flag_zero` is set when the result is all zeros.
  - Flags change only in EXEC and hold otherwise.
- **WB**
  - `wb_addr` = `rd`, `wb_data` = result.
  - `wb_we` = 1 only if `rd` != 0. Register 0 is hardwired zero, so the write is suppressed.
  - `done` = 1 for this cycle regardless of `rd`. Go to IDLE.
- **Outputs outside WB:** `wb_we` = 0 and `done` = 0.
- **Reset values** (asynchronous, immediate):
  - state = IDLE.
  - `op_ready` = 1.
  - `rd_addr1`, `rd_addr2`, `wb_we`, `wb_addr`, `wb_data`, `flag_zero`, `flag_carry`, `done` = 0.
  - Reset mid-instruction abandons the instruction. No write is issued after `rst_n` falls.

## Timing
- **Issue cadence:** with the handshake accepted at edge 0:
  - READ in cycle 1.
  - EXEC in cycle 2.
  - WB in cycle 3; the register file writes at edge 4.
  - `op_ready` is high again in cycle 4.
  - Maximum issue rate is one instruction per 4 cycles.
- **Read-after-write:** the next instruction reads no earlier than cycle 5, after the write at edge 4, so no forwarding is needed.
- **Combinational path:** `rd_data*` → operand latch is the only combinational input path. Outputs have no combinational paths.

## Configuration
- **`ALU_SHIFT_EN`**
  - Defined: opcodes 101 and 110 shift as specified.
  - Undefined: the shifter is not built, and opcodes 101 and 110 behave as PASS (result = A, carry = 0).

## Structure
- **Package `alu_pkg`:**
  - Opcode localparams: `OP_ADD` … `OP_PASS`.
  - FSM state encoding: `ST_IDLE`, `ST_READ`, `ST_EXEC`, `ST_WB`.
  - Register address width: 3.
- **Sub-module `alu_core`:**
  - Purely combinational.
  - Inputs: A, B, op. Outputs: result, carry.
  - Holds the `ALU_SHIFT_EN` guard.
- **Top level:** holds the FSM, the latches and the output registers.

## Test plan
- **Write-back:** preload r1=5, r2=3; issue ADD rd=4 → `wb_we`=1, `wb_addr`=4, `wb_data`=8 in cycle 3, `done` pulses, `flag_carry`=0, `flag_zero`=0.
- **Overflow:** r1=9, r2=9, ADD rd=5 → `wb_data`=2, `flag_carry`=1.
- **Borrow:** r1=3, r2=5, SUB rd=6 → `wb_data`=14, `flag_carry`=1.
- **Zero:** XOR r1,r1 rd=7 → `wb_data`=0, `flag_zero`=1.
- **Register 0:** PASS rs1=2 (r2=0xA) rd=0 → `wb_we` stays 0 and `done` still pulses.
- **Shift:** SLL r1=0x3, r2=0x2 → 0xC with `ALU_SHIFT_EN`, 0x3 without.
- **Handshake:** hold `op_valid` high continuously → an accept every 4th cycle only, and `op_ready` low for 3 cycles after each accept.
- **Reset during EXEC:** → `wb_we` never asserts, outputs go to reset values immediately, and `op_ready`=1.
